// File: rtl/mod_counter_scheduler_if.sv
// Request/grant bundle between timing clients and the shared-counter scheduler.
// The master side (clients) drives requests, durations and pause; the slave
// side (scheduler) returns grant, the shared count, completion and busy.
interface mod_counter_scheduler_if #(
    parameter int NREQ = 4,
    parameter int CW   = 4
);
    logic [NREQ-1:0]    req;
    logic [NREQ*CW-1:0] dur;
    logic               hold;
    logic [NREQ-1:0]    gnt;
    logic [CW-1:0]      count;
    logic [NREQ-1:0]    done;
    logic               busy;

    modport master (
        output req, dur, hold,
        input  gnt, count, done, busy
    );

    modport slave (
        input  req, dur, hold,
        output gnt, count, done, busy
    );
endinterface

// File: rtl/mod_counter_scheduler.sv
// Round-robin scheduler sharing one mod-MOD up-counter among NREQ requesters.
// A granted requester sees the counter run 0..min(dur, MOD-1), then gets a
// one-cycle done pulse. The requester just served drops to lowest priority.
module mod_counter_scheduler #(
    parameter int NREQ = 4,
    parameter int CW   = 4,
    parameter int MOD  = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    mod_counter_scheduler_if.slave  bus
);
    localparam int            PW       = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [CW-1:0] TERM_MAX = CW'(MOD - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [NREQ-1:0] gnt_q,   gnt_d;
    logic [NREQ-1:0] done_q,  done_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   term_q,  term_d;
    logic [PW-1:0]   ptr_q,   ptr_d;
    logic [PW-1:0]   g_q,     g_d;

    logic            found;
    logic [PW-1:0]   sel_idx;
    logic [CW-1:0]   sel_dur;
    logic [PW-1:0]   g_next;

    // Round-robin pick: first set request at or after ptr, wrapping.
    always_comb begin
        found   = 1'b0;
        sel_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && bus.req[(int'(ptr_q) + k) % NREQ]) begin
                found   = 1'b1;
                sel_idx = PW'((int'(ptr_q) + k) % NREQ);
            end
        end
    end

    assign sel_dur = bus.dur[int'(sel_idx)*CW +: CW];
    assign g_next  = (int'(g_q) == NREQ - 1) ? '0 : g_q + 1'b1;

    // Next-state and output decode; abort beats pause beats terminal count.
    always_comb begin
        // NOTE: every target gets a default first so no path can infer a latch.
        state_d = state_q;
        gnt_d   = gnt_q;
        count_d = count_q;
        done_d  = '0;
        term_d  = term_q;
        ptr_d   = ptr_q;
        g_d     = g_q;
        unique case (state_q)
            ST_IDLE: begin
                if (found) begin
                    g_d     = sel_idx;
                    term_d  = (sel_dur > TERM_MAX) ? TERM_MAX : sel_dur;
                    gnt_d   = NREQ'(1) << sel_idx;
                    count_d = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!bus.req[g_q]) begin
                    gnt_d   = '0;
                    count_d = '0;
                    ptr_d   = g_next;
                    state_d = ST_IDLE;
                end else if (bus.hold) begin
                    state_d = ST_RUN;
                end else if (count_q == term_q) begin
                    gnt_d   = '0;
                    count_d = '0;
                    done_d  = NREQ'(1) << g_q;
                    ptr_d   = g_next;
                    state_d = ST_DONE;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                gnt_d   = '0;
                count_d = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register; reset clears everything immediately, with no done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            done_q  <= '0;
            count_q <= '0;
            term_q  <= '0;
            ptr_q   <= '0;
            g_q     <= '0;
        end else begin
            // NOTE: non-blocking updates so every flop samples pre-edge values.
            state_q <= state_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            count_q <= count_d;
            term_q  <= term_d;
            ptr_q   <= ptr_d;
            g_q     <= g_d;
        end
    end

    assign bus.gnt   = gnt_q;
    assign bus.done  = done_q;
    assign bus.count = count_q;
    assign bus.busy  = (state_q != ST_IDLE);
endmodule

// File: tb/tb_mod_counter_scheduler.sv
// Self-checking bench for mod_counter_scheduler: directed vectors with
// hand-computed expectations, plus a per-cycle comparison against an
// owner/interval model of the scheduling rules.
module tb_mod_counter_scheduler;
    localparam int NREQ = 4;
    localparam int CW   = 4;
    localparam int MOD  = 10;

    logic clk;
    logic rst;

    mod_counter_scheduler_if #(.NREQ(NREQ), .CW(CW)) bus ();

    mod_counter_scheduler #(.NREQ(NREQ), .CW(CW), .MOD(MOD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [NREQ-1:0] onehot(input int i);
        return (i >= 0) ? (NREQ'(1) << i) : '0;
    endfunction

    // Model: who owns the counter (-1 = nobody), its count and terminal,
    // which requester is showing done (-1 = none), and who was served last.
    int m_owner, m_count, m_term, m_done, m_last;

    always @(posedge clk or posedge rst) begin : model
        int pick, d, idx;
        if (rst) begin
            m_owner <= -1;
            m_count <= 0;
            m_term  <= 0;
            m_done  <= -1;
            m_last  <= NREQ - 1;
        end else if (m_done >= 0) begin
            m_done <= -1;
        end else if (m_owner < 0) begin
            pick = -1;
            for (int k = 0; k < NREQ; k++) begin
                idx = (m_last + 1 + k) % NREQ;
                if (pick < 0 && bus.req[idx]) pick = idx;
            end
            if (pick >= 0) begin
                d = int'(bus.dur[pick*CW +: CW]);
                m_owner <= pick;
                m_term  <= (d > MOD - 1) ? MOD - 1 : d;
                m_count <= 0;
            end
        end else if (!bus.req[m_owner]) begin
            m_owner <= -1;
            m_count <= 0;
            m_last  <= m_owner;
        end else if (bus.hold) begin
            m_count <= m_count;
        end else if (m_count == m_term) begin
            m_done  <= m_owner;
            m_owner <= -1;
            m_count <= 0;
            m_last  <= m_owner;
        end else begin
            m_count <= m_count + 1;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (mon_en) begin
            check("model_gnt",   32'(bus.gnt),   32'(onehot(m_owner)));
            check("model_count", 32'(bus.count), m_count);
            check("model_done",  32'(bus.done),  32'(onehot(m_done)));
            check("model_busy",  32'(bus.busy),  32'((m_owner >= 0) || (m_done >= 0)));
            check("gnt_done_excl", 32'(bus.gnt & bus.done), 32'd0);
        end
    end

    task automatic expect_cyc(input string tag, input logic [3:0] g, input int c,
                              input logic [3:0] d, input logic b);
        @(negedge clk);
        check({tag, "_gnt"},   32'(bus.gnt),   32'(g));
        check({tag, "_count"}, 32'(bus.count), c);
        check({tag, "_done"},  32'(bus.done),  32'(d));
        check({tag, "_busy"},  32'(bus.busy),  32'(b));
    endtask

    task automatic set_dur(input int i, input int v);
        bus.dur[i*CW +: CW] = CW'(v);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        rst      = 1'b1;
        bus.req  = '0;
        bus.dur  = '0;
        bus.hold = 1'b0;

        // 1: reset and idle
        repeat (2) @(negedge clk);
        check("rst_gnt",   32'(bus.gnt),   32'd0);
        check("rst_count", 32'(bus.count), 32'd0);
        check("rst_done",  32'(bus.done),  32'd0);
        check("rst_busy",  32'(bus.busy),  32'd0);
        rst    = 1'b0;
        mon_en = 1'b1;
        repeat (3) expect_cyc("idle", 4'b0000, 0, 4'b0000, 1'b0);

        // 2: single requester, dur=3
        set_dur(0, 3);
        bus.req = 4'b0001;
        for (int k = 0; k <= 3; k++) expect_cyc("t2_run", 4'b0001, k, 4'b0000, 1'b1);
        expect_cyc("t2_done", 4'b0000, 0, 4'b0001, 1'b1);
        bus.req = 4'b0000;
        expect_cyc("t2_idle", 4'b0000, 0, 4'b0000, 1'b0);

        // 3: all four requesting with dur=1, round-robin from 0
        do_reset();
        for (int i = 0; i < NREQ; i++) set_dur(i, 1);
        bus.req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            expect_cyc("t3_c0", 4'(1 << (n % 4)), 0, 4'b0000, 1'b1);
            expect_cyc("t3_c1", 4'(1 << (n % 4)), 1, 4'b0000, 1'b1);
            expect_cyc("t3_done", 4'b0000, 0, 4'(1 << (n % 4)), 1'b1);
            if (n == 4) bus.req = 4'b0000;
            expect_cyc("t3_gap", 4'b0000, 0, 4'b0000, 1'b0);
        end

        // 4: dur clamped to MOD-1; dur changed after latching is ignored
        set_dur(0, 15);
        bus.req = 4'b0001;
        expect_cyc("t4_run", 4'b0001, 0, 4'b0000, 1'b1);
        set_dur(0, 2);
        for (int k = 1; k <= 9; k++) expect_cyc("t4_run", 4'b0001, k, 4'b0000, 1'b1);
        expect_cyc("t4_done", 4'b0000, 0, 4'b0001, 1'b1);
        bus.req = 4'b0000;
        expect_cyc("t4_idle", 4'b0000, 0, 4'b0000, 1'b0);

        // 5: hold for 3 cycles at count 2; 9 granted cycles in total
        set_dur(0, 5);
        bus.req = 4'b0001;
        for (int k = 0; k <= 2; k++) expect_cyc("t5_run", 4'b0001, k, 4'b0000, 1'b1);
        bus.hold = 1'b1;
        for (int k = 0; k < 3; k++) expect_cyc("t5_hold", 4'b0001, 2, 4'b0000, 1'b1);
        bus.hold = 1'b0;
        for (int k = 3; k <= 5; k++) expect_cyc("t5_run", 4'b0001, k, 4'b0000, 1'b1);
        expect_cyc("t5_done", 4'b0000, 0, 4'b0001, 1'b1);
        bus.req = 4'b0000;
        expect_cyc("t5_idle", 4'b0000, 0, 4'b0000, 1'b0);

        // 6a: abort req0 at count 2 with req1 pending
        set_dur(0, 5);
        set_dur(1, 2);
        bus.req = 4'b0001;
        expect_cyc("t6_run", 4'b0001, 0, 4'b0000, 1'b1);
        bus.req = 4'b0011;
        expect_cyc("t6_run", 4'b0001, 1, 4'b0000, 1'b1);
        expect_cyc("t6_run", 4'b0001, 2, 4'b0000, 1'b1);
        bus.req = 4'b0010;
        expect_cyc("t6_abort", 4'b0000, 0, 4'b0000, 1'b0);
        for (int k = 0; k <= 2; k++) expect_cyc("t6_r1", 4'b0010, k, 4'b0000, 1'b1);
        expect_cyc("t6_done1", 4'b0000, 0, 4'b0010, 1'b1);
        bus.req = 4'b0000;
        expect_cyc("t6_idle", 4'b0000, 0, 4'b0000, 1'b0);

        // 6b: asynchronous reset mid-interval clears outputs before next edge
        bus.req = 4'b0001;
        for (int k = 0; k <= 2; k++) expect_cyc("t6_rrun", 4'b0001, k, 4'b0000, 1'b1);
        #2;
        rst     = 1'b1;
        bus.req = 4'b0000;
        #1;
        check("t6_arst_gnt",   32'(bus.gnt),   32'd0);
        check("t6_arst_count", 32'(bus.count), 32'd0);
        check("t6_arst_done",  32'(bus.done),  32'd0);
        check("t6_arst_busy",  32'(bus.busy),  32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) expect_cyc("t6_post", 4'b0000, 0, 4'b0000, 1'b0);

        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
